// File: rtl/uart_pkg.sv
// Shared types and constants for the RS-232 UART receiver.
// Framing is 1 start, 1..8 data bits LSB-first, 1 stop, no parity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;
  localparam logic [3:0] MAX_BITS   = 4'd8;

  // 0 and anything above 8 fall back to a full byte
  function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
    if (n == 4'd0 || n > MAX_BITS)
      return MAX_BITS;
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle line is never mistaken for a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rs232_rx.sv
// RS-232 receiver: 16x oversampled, mid-bit start validation,
// 1..8 data bits LSB-first, stop check with break hold-off.
module uart_rs232_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Rx,
  input  logic [3:0] NBits,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr
);

  rx_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic       rx_s;
  logic [3:0] nb;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(Clk),
    .rst_i(Rst),
    .d_i  (Rx),
    .q_o  (rx_s)
  );

  assign nb = clamp_nbits(NBits);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    if (Tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == MID_TICK) begin
            if (!rx_s) begin
              cnt_d   = '0;
              idx_d   = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_TICK) begin
            sh_d  = {rx_s, sh_q[7:1]};
            idx_d = idx_q + 4'd1;
            if (idx_q + 4'd1 == nb)
              state_d = STOP;
          end
        end
        STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_TICK) begin
            // short frames land high in sh_q; realign to bit 0
            data_d  = sh_q >> (MAX_BITS - nb);
            done_d  = 1'b1;
            ferr_d  = !rx_s;
            state_d = rx_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (rx_s)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign RxData   = data_q;
  assign RxDone   = done_q;
  assign FrameErr = ferr_q;

endmodule

// File: tb/tb_uart_rs232_rx.sv
// Directed bench for uart_rs232_rx: a behavioural line driver
// at nominal baud, Tick every 4 Clk, and a RxDone logger.
module tb_uart_rs232_rx;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Tick = 1'b0;
  logic       Rx = 1'b1;
  logic [3:0] NBits = 4'd8;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;

  int n_tests = 0;
  int n_fail  = 0;
  int n_dbl   = 0;
  logic [1:0] tdiv = 2'd0;
  logic       prev_done = 1'b0;
  logic [7:0] log_d[$];
  logic       log_e[$];

  uart_rs232_rx dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Tick    (Tick),
    .Rx      (Rx),
    .NBits   (NBits),
    .RxData  (RxData),
    .RxDone  (RxDone),
    .FrameErr(FrameErr)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    tdiv = tdiv + 2'd1;
    Tick = (tdiv == 2'd0);
  end

  always @(negedge Clk) begin
    if (RxDone) begin
      log_d.push_back(RxData);
      log_e.push_back(FrameErr);
      if (prev_done)
        n_dbl++;
    end
    prev_done = RxDone;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge Clk); while (!Tick);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic drive_bit(input logic v);
    @(negedge Clk) Rx = v;
    wait_ticks(16);
  endtask

  task automatic send(input logic [7:0] d, input int nb, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++)
      drive_bit(d[i]);
    drive_bit(stp);
  endtask

  task automatic idle(input int n);
    @(negedge Clk) Rx = 1'b1;
    wait_ticks(n);
  endtask

  task automatic expect_frame(input string tag, input int n0,
                              input logic [7:0] d, input logic e);
    int k;
    k = log_d.size();
    chk({tag, "_cnt"}, k - n0, 1);
    if (k > 0) begin
      chk({tag, "_data"}, log_d[k-1], d);
      chk({tag, "_ferr"}, log_e[k-1], e);
    end
  endtask

  initial begin
    int n0;
    logic [7:0] b2b[4];
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h5A;
    b2b[3] = 8'hC3;

    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_data", RxData, 8'h00);
    chk("rst_done", RxDone, 1'b0);
    chk("rst_ferr", FrameErr, 1'b0);
    idle(20);
    chk("rst_nodone", log_d.size(), 0);

    n0 = log_d.size();
    send(8'hA5, 8, 1'b1);
    idle(20);
    expect_frame("a5", n0, 8'hA5, 1'b0);

    NBits = 4'd7;
    n0 = log_d.size();
    send(8'h55, 7, 1'b1);
    idle(20);
    expect_frame("n7_55", n0, 8'h55, 1'b0);

    NBits = 4'd1;
    n0 = log_d.size();
    send(8'h01, 1, 1'b1);
    idle(20);
    expect_frame("n1", n0, 8'h01, 1'b0);

    NBits = 4'd0;
    n0 = log_d.size();
    send(8'hE7, 8, 1'b1);
    idle(20);
    expect_frame("n0_e7", n0, 8'hE7, 1'b0);
    NBits = 4'd8;

    n0 = log_d.size();
    @(negedge Clk) Rx = 1'b0;
    wait_ticks(4);
    idle(40);
    chk("glitch_nodone", log_d.size() - n0, 0);
    n0 = log_d.size();
    send(8'h3C, 8, 1'b1);
    idle(20);
    expect_frame("3c", n0, 8'h3C, 1'b0);

    n0 = log_d.size();
    send(8'h81, 8, 1'b0);
    wait_ticks(40);
    expect_frame("brk_81", n0, 8'h81, 1'b1);
    idle(40);
    chk("brk_single", log_d.size() - n0, 1);
    chk("brk_hold", FrameErr, 1'b1);
    n0 = log_d.size();
    send(8'h96, 8, 1'b1);
    idle(20);
    expect_frame("brk_clr", n0, 8'h96, 1'b0);

    n0 = log_d.size();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    @(negedge Clk) Rx = 1'b1;
    wait_ticks(8);
    @(negedge Clk) Rst = 1'b1;
    @(negedge Clk) Rst = 1'b0;
    chk("mrst_data", RxData, 8'h00);
    chk("mrst_done", RxDone, 1'b0);
    chk("mrst_ferr", FrameErr, 1'b0);
    idle(60);
    chk("mrst_nodone", log_d.size() - n0, 0);
    n0 = log_d.size();
    send(8'h0F, 8, 1'b1);
    idle(20);
    expect_frame("post_rst_0f", n0, 8'h0F, 1'b0);

    n0 = log_d.size();
    for (int i = 0; i < 4; i++)
      send(b2b[i], 8, 1'b1);
    idle(20);
    chk("b2b_cnt", log_d.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      if (n0 + i < log_d.size()) begin
        chk($sformatf("b2b_data%0d", i), log_d[n0+i], b2b[i]);
        chk($sformatf("b2b_ferr%0d", i), log_e[n0+i], 1'b0);
      end
    end

    chk("done_single_cycle", n_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rs232_rx.md
# uart_rs232_rx

Serial receiver that consumes the line driven by the RS-232 transmitter and recovers parallel bytes. It samples `Rx` using a 16x oversampling `Tick` from the shared baud generator and validates the start bit at mid-bit. It assembles 1–8 data bits LSB-first and checks the stop bit. Each completed frame is presented on `RxData` with a one-cycle `RxDone` pulse. It sits at the board-facing edge of the UART, mirrors the transmitter's framing (1 start, NBits data, 1 stop, no parity), and feeds the processor-side consumer.

## Interface
- `OVERSAMPLE`, default 16: Ticks per bit. Fixed; not user-overridable.
- `SYNC_STAGES`, default 2: metastability flops on `Rx`.
- `Clk`, in, 1: system clock; all logic on rising edge.
- `Rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `Tick`, in, 1: single-`Clk`-cycle enable at 16x baud, synchronous to `Clk`.
- `Rx`, in, 1: asynchronous serial line; idle high.
- `NBits`, in, 4: data bits per frame. Must be stable while a frame is in progress. 1–8 are legal; 0 and values above 8 are treated as 8.
- `RxData`, out, 8: last received word, right-aligned, upper bits zero.
- `RxDone`, out, 1: one-`Clk` pulse when a frame completes.
- `FrameErr`, out, 1: stop bit of the last frame sampled low. Valid with `RxDone` and held until the next `RxDone`.

## Operation
- `Rx` passes through `SYNC_STAGES` flops to give `rx_s`. The sync flops reset to 1.
- The state machine has five states: IDLE, START, DATA, STOP, BREAK.
- **IDLE:** on a `Tick` with `rx_s`=0, clear the tick counter and go to START.
- **START:** count Ticks. At counter 7 (the 8th Tick, mid-bit):
  - if `rx_s`=0, clear the counter and bit index and go to DATA;
  - otherwise go to IDLE (glitch rejected, no output).
- **DATA:** count Ticks. At counter 15, sample `rx_s` into the shift register and advance the bit index. Bits shift in at bit 7 and move right, so bit 0 is received first. After `NBits` samples, go to STOP.
- **STOP:** at counter 15, sample `rx_s`:
  - Load `RxData` with the shift register right-shifted by (8−NBits), so the upper bits are zero.
  - Pulse `RxDone` and set `FrameErr` to NOT(sample).
  - If the sample is 1, go to IDLE. If it is 0, go to BREAK.
- **BREAK:** wait for a `Tick` with `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- The tick counter is 4 bits and wraps 15→0. The bit index is 4 bits. Counter and index advance only on `Tick`.
- `RxData` and `FrameErr` hold their values between frames. `RxDone` is never high for two consecutive `Clk` cycles.
- `Rst` asserted in any state: go to IDLE, clear the counters and shift register, and force `RxData`=0, `RxDone`=0, `FrameErr`=0. Any partial frame is discarded and produces no `RxDone`.
- `Tick` is ignored while `Rst` is high.

## Timing
- Reset values: `RxData`=8'h00, `RxDone`=0, `FrameErr`=0, state IDLE.
- Input latency: 2 `Clk` cycles of synchronizer delay from `Rx` to `rx_s`.
- Start detection happens on the first `Tick` that sees `rx_s` low, which is up to 1 Tick after the edge.
- Sample points relative to the detected start: mid-start at Tick 8, data bit k at Tick 8+16(k+1), stop at Tick 8+16(NBits+1).
- `RxDone`, `RxData` and `FrameErr` are registered. They update in the `Clk` cycle after the `Tick` cycle that samples the stop bit.
- Back-to-back frames: a new start edge is accepted on the first `Tick` in IDLE. After the stop sample there are about 7 Ticks of margin before the next start edge arrives from a transmitter at nominal baud.
- Baud tolerance: ±3% mismatch between transmitter and receiver must decode 8N1 correctly.

## Structure
- Package `uart_pkg` holds:
  - the state enum `rx_state_t` (IDLE, START, DATA, STOP, BREAK);
  - the constants `OVERSAMPLE`=16, `MID_TICK`=7, `LAST_TICK`=15, `MAX_BITS`=8;
  - the function that clamps `NBits`.
- Sub-module `uart_rx_sync` is the parameterised N-flop synchronizer with a reset value of 1. Everything else stays flat in `uart_rs232_rx`.

## Test plan
- 8N1 frame 0xA5 at 16 Ticks/bit, Tick every 4 `Clk` → one `RxDone` pulse, `RxData`=8'hA5, `FrameErr`=0.
- `NBits`=7, frame 0x55 → `RxData`=8'h55 (bit 7 = 0), stop sampled after 7 data bits.
- `Rx` low for 4 Ticks then high → no `RxDone`, state returns to IDLE. A following valid 0x3C is received correctly.
- 0x81 with stop bit driven low, line then held low for 40 Ticks, then high → exactly one `RxDone`, `FrameErr`=1, `RxData`=8'h81, no further pulses. The next valid frame clears `FrameErr`.
- Assert `Rst` for 1 `Clk` in the middle of DATA bit 3 → outputs are 0, no `RxDone`. The next full frame 0x0F decodes correctly.
- Loopback with the transmitter, sharing `Tick`, sending 0x00, 0xFF, 0x5A, 0xC3 back-to-back → four `RxDone` pulses with matching data and `FrameErr`=0 throughout.
